// File: rtl/alu_pkg.sv
// Shared constants for the RV32I ALU issue path: ALU op codes, the two
// decoded opcode classes, the funct7 variants and the error codes.
package alu_pkg;

    // ALU op codes, OP-IMM class first, then OP class
    localparam logic [5:0] ALU_ADDI  = 6'd0;
    localparam logic [5:0] ALU_SLTI  = 6'd1;
    localparam logic [5:0] ALU_SLTIU = 6'd2;
    localparam logic [5:0] ALU_XORI  = 6'd3;
    localparam logic [5:0] ALU_ORI   = 6'd4;
    localparam logic [5:0] ALU_ANDI  = 6'd5;
    localparam logic [5:0] ALU_SLLI  = 6'd6;
    localparam logic [5:0] ALU_SRLI  = 6'd7;
    localparam logic [5:0] ALU_SRAI  = 6'd8;
    localparam logic [5:0] ALU_ADD   = 6'd9;
    localparam logic [5:0] ALU_SUB   = 6'd10;
    localparam logic [5:0] ALU_SLL   = 6'd11;
    localparam logic [5:0] ALU_SLT   = 6'd12;
    localparam logic [5:0] ALU_SLTU  = 6'd13;
    localparam logic [5:0] ALU_XOR   = 6'd14;
    localparam logic [5:0] ALU_SRL   = 6'd15;
    localparam logic [5:0] ALU_SRA   = 6'd16;
    localparam logic [5:0] ALU_OR    = 6'd17;
    localparam logic [5:0] ALU_AND   = 6'd18;

    // Major opcodes handled by this stage
    localparam logic [6:0] OPC_OPIMM = 7'h13;
    localparam logic [6:0] OPC_OP    = 7'h33;

    // funct7 variants: base encoding and the SUB/SRA/SRAI alternate
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // Error codes reported alongside an issued bundle
    localparam logic [31:0] ERR_NONE    = 32'd0;
    localparam logic [31:0] ERR_ILLEGAL = 32'd1;

endpackage

// File: rtl/alu_op_decode.sv
// Purely combinational decoder: opcode/funct3/funct7 to ALU op code,
// immediate-operand select and an illegal flag. An illegal encoding
// always reports op 0 with the register operand selected.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [5:0] alu_op,
    output logic       use_imm,
    output logic       illegal
);

    // Decode the two supported classes; anything unmatched stays illegal
    always_comb begin
        alu_op  = ALU_ADDI;
        use_imm = 1'b0;
        illegal = 1'b1;
        if (opcode == OPC_OPIMM) begin
            use_imm = 1'b1;
            illegal = 1'b0;
            case (funct3)
                3'b000: alu_op = ALU_ADDI;
                3'b010: alu_op = ALU_SLTI;
                3'b011: alu_op = ALU_SLTIU;
                3'b100: alu_op = ALU_XORI;
                3'b110: alu_op = ALU_ORI;
                3'b111: alu_op = ALU_ANDI;
                3'b001: begin
                    if (funct7 == F7_BASE) alu_op = ALU_SLLI;
                    else                   illegal = 1'b1;
                end
                3'b101: begin
                    if      (funct7 == F7_BASE) alu_op = ALU_SRLI;
                    else if (funct7 == F7_ALT)  alu_op = ALU_SRAI;
                    else                        illegal = 1'b1;
                end
            endcase
        end else if (opcode == OPC_OP) begin
            if (funct7 == F7_BASE) begin
                illegal = 1'b0;
                case (funct3)
                    3'b000: alu_op = ALU_ADD;
                    3'b001: alu_op = ALU_SLL;
                    3'b010: alu_op = ALU_SLT;
                    3'b011: alu_op = ALU_SLTU;
                    3'b100: alu_op = ALU_XOR;
                    3'b101: alu_op = ALU_SRL;
                    3'b110: alu_op = ALU_OR;
                    3'b111: alu_op = ALU_AND;
                endcase
            end else if (funct7 == F7_ALT) begin
                case (funct3)
                    3'b000: begin
                        alu_op  = ALU_SUB;
                        illegal = 1'b0;
                    end
                    3'b101: begin
                        alu_op  = ALU_SRA;
                        illegal = 1'b0;
                    end
                    default: illegal = 1'b1;
                endcase
            end
        end
        if (illegal) begin
            alu_op  = ALU_ADDI;
            use_imm = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the combinational ALU. Decodes OP-IMM
// and OP instructions, reads operands with write-back bypass and holds
// the issued bundle in a single output register.
//
// Handshake (both sides): a beat moves when valid && ready in the same
// cycle; valid never depends on ready; while out_valid && !out_ready the
// output register is frozen. in_ready = !out_valid || out_ready, so a
// consume and an accept in one cycle replace the bundle without a bubble.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] ILLEGAL_CODE = XLEN'(ERR_ILLEGAL)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_rdata,
    input  logic [XLEN-1:0] rs2_rdata,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [5:0]      alu_op,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [4:0]      alu_shamt,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal,
    output logic [XLEN-1:0] err_code
);

    logic [5:0]      dec_op;
    logic            dec_use_imm;
    logic            dec_illegal;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_val;
    logic [XLEN-1:0] in2_val;
    logic            accept;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign imm_val  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

    alu_op_decode u_decode (
        .opcode  (in_instr[6:0]),
        .funct3  (in_instr[14:12]),
        .funct7  (in_instr[31:25]),
        .alu_op  (dec_op),
        .use_imm (dec_use_imm),
        .illegal (dec_illegal)
    );

    // Operand read: x0 reads zero, a same-cycle write-back wins over the register file
    always_comb begin
        rs1_val = rs1_rdata;
        rs2_val = rs2_rdata;
        if (rs1_addr == 5'd0)
            rs1_val = '0;
        else if (wb_we && wb_rd == rs1_addr)
            rs1_val = wb_data;
        if (rs2_addr == 5'd0)
            rs2_val = '0;
        else if (wb_we && wb_rd == rs2_addr)
            rs2_val = wb_data;
        in2_val = dec_use_imm ? imm_val : rs2_val;
    end

    // Output register: reset beats flush, flush beats a transfer, an idle consume empties it
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            alu_op    <= '0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            alu_shamt <= '0;
            rd        <= '0;
            rd_we     <= 1'b0;
            illegal   <= 1'b0;
            err_code  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            alu_op    <= dec_op;
            alu_in1   <= rs1_val;
            alu_in2   <= in2_val;
            alu_shamt <= in_instr[24:20];
            rd        <= in_instr[11:7];
            rd_we     <= !dec_illegal && (in_instr[11:7] != 5'd0);
            illegal   <= dec_illegal;
            err_code  <= dec_illegal ? ILLEGAL_CODE : '0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
